alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Sequencer that feeds the 8-bit combinational ALU core from a byte-wide valid/ready input stream. It collects the operands, drives the ALU operand/opcode lines for one execute cycle and captures result plus Z/N/C/V flags into an output register with valid/ready handshake. It supports accumulator chaining, where the previous result becomes A, and a watchdog on incomplete transactions. It sits between the chip I/O byte interface and the ALU core.

Parameters:
TIMEOUT_CYCLES, 255, max idle cycles waiting for operand B before abort; 0 disables the watchdog (range 0..255)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input byte valid
in_ready  out  1  controller accepts input byte this cycle
in_data  in  8  operand byte
in_op  in  3  ALU opcode, sampled only on the first beat of a transaction
in_chain  in  1  sampled on first beat: use accumulator as A, in_data is B
alu_a  out  8  operand A to ALU core (registered)
alu_b  out  8  operand B to ALU core (registered)
alu_op  out  3  opcode to ALU core (registered)
alu_r  in  8  ALU result
alu_flags  in  4  ALU {Zero,Negative,Carry,Overflow}
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  8  captured result
out_flags  out  4  captured {Z,N,C,V}, bit3=Z … bit0=V
op_count  out  8  completed transactions, wraps 255->0
err  out  1  one-cycle pulse on watchdog abort
busy  out  1  high in any state other than S_A

Behaviour:
- States: S_A, S_B, S_EXEC, S_OUT. Reset state is S_A.
- Reset (any state, including mid-transaction): state=S_A; alu_a/alu_b/alu_op=0; out_data=0; out_flags=0; out_valid=0; op_count=0; err=0; acc=0; acc_valid=0; watchdog=0.
- Unary ops: op 100, 101, 110, 111 need no B; alu_b is forced to 0 for them.
- in_ready=1 only in S_A and S_B. A beat is accepted on in_valid & in_ready.
- S_A, on accept: op latched to alu_op.
  - in_chain=1: alu_a=acc (0x00 if acc_valid=0), alu_b=in_data (0 if unary) -> S_EXEC.
  - in_chain=0, unary op: alu_a=in_data, alu_b=0 -> S_EXEC.
  - in_chain=0, binary op: alu_a=in_data -> S_B; watchdog cleared.
- S_B, on accept: alu_b=in_data -> S_EXEC.
- S_B, no accept: watchdog increments each cycle. When it reaches TIMEOUT_CYCLES (nonzero): err=1 for one cycle, -> S_A. acc, op_count and out_* are unchanged.
- S_EXEC (exactly 1 cycle): ALU inputs are stable. At the clock edge: out_data=alu_r, out_flags=alu_flags, acc=alu_r, acc_valid=1, out_valid=1 -> S_OUT.
- S_OUT: out_valid held high. out_data/out_flags/alu_* stay stable until out_ready.
  - On out_valid & out_ready: out_valid=0, op_count+=1 (mod 256) -> S_A.
  - The next transaction's first beat can be accepted the cycle after the handshake.
- Latency (accept to out_valid high): binary op with no stalls, B accepted at t+1, out_valid at t+3. Chained or unary op, out_valid at t+2.
- Throughput: at most 1 result per 3 cycles (unary/chain) or per 4 cycles (binary).
- in_op and in_chain are ignored on the B beat.
- in_valid in S_EXEC/S_OUT is not consumed; the source holds it.
- Flags pass through unaltered from the ALU. Carry on SUB means no-borrow. Overflow is defined only for ADD.
- err and an out_valid handshake never occur in the same cycle (disjoint states).

Test Plan:
- ADD: A=0x7F, B=0x01, op=000, out_ready=1 -> out_data=0x80, out_flags=4'b0101, out_valid exactly 3 cycles after A accept, op_count=1.
- SUB then chain: 0x05-0x05 -> 0x00, flags 4'b1010. Then chained ADD with B=0x80 -> A=0x00, result 0x80, flags 4'b0100, one input beat only.
- Unary SHL: A=0x81, op=100, single beat -> alu_b=0, out_data=0x02, out_flags=4'b0000, out_valid 2 cycles after accept.
- Backpressure: out_ready low 5 cycles after out_valid -> out_data/out_flags constant, in_ready=0, op_count unchanged. Raising out_ready completes the transfer and increments op_count once.
- Watchdog: TIMEOUT_CYCLES=4, A accepted, in_valid held low -> err pulses once 4 cycles later, state back to S_A, op_count/acc unchanged. The next beat is treated as a new A.
- Reset in S_EXEC and in S_OUT -> all outputs at reset values next cycle. A chained op then uses A=0x00.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_ctrl
//  Description : Byte-stream sequencer for the 8-bit ALU core. It collects the
//                operands, presents them to the ALU for one execute cycle and
//                captures result and flags behind a valid/ready output stage.
//                It also supports accumulator chaining and an operand-B
//                watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [2:0] in_op,
    input  logic       in_chain,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_r,
    input  logic [3:0] alu_flags,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [3:0] out_flags,
    output logic [7:0] op_count,
    output logic       err,
    output logic       busy
);

    localparam logic [1:0] S_A    = 2'd0;
    localparam logic [1:0] S_B    = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [8:0] c_timeout = 9'(TIMEOUT_CYCLES);

    logic [1:0] r_state;
    logic [7:0] r_acc;
    logic       r_acc_valid;
    logic [7:0] r_wdog;

    logic       w_accept;
    logic       w_unary;
    logic [8:0] w_wdog_next;
    logic       w_timeout;

    // Handshake and watchdog decode from current state and inputs
    always_comb begin
        in_ready    = (r_state == S_A) || (r_state == S_B);
        busy        = (r_state != S_A);
        w_accept    = in_valid && in_ready;
        // Opcodes 1xx (shifts/unary ops) take no B operand
        w_unary     = in_op[2];
        w_wdog_next = {1'b0, r_wdog} + 9'd1;
        // A zero timeout disables the abort entirely
        w_timeout   = (c_timeout != 9'd0) && (w_wdog_next == c_timeout);
    end

    // Sequencer state, ALU operand registers, output stage and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_A;
            alu_a       <= 8'h00;
            alu_b       <= 8'h00;
            alu_op      <= 3'b000;
            out_data    <= 8'h00;
            out_flags   <= 4'h0;
            out_valid   <= 1'b0;
            op_count    <= 8'h00;
            err         <= 1'b0;
            r_acc       <= 8'h00;
            r_acc_valid <= 1'b0;
            r_wdog      <= 8'h00;
        end else begin
            // err is a single-cycle pulse; only the timeout branch raises it
            err <= 1'b0;
            case (r_state)
                S_A: begin
                    if (w_accept) begin
                        alu_op <= in_op;
                        if (in_chain) begin
                            alu_a   <= r_acc_valid ? r_acc : 8'h00;
                            alu_b   <= w_unary ? 8'h00 : in_data;
                            r_state <= S_EXEC;
                        end else if (w_unary) begin
                            alu_a   <= in_data;
                            alu_b   <= 8'h00;
                            r_state <= S_EXEC;
                        end else begin
                            alu_a   <= in_data;
                            r_wdog  <= 8'h00;
                            r_state <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (w_accept) begin
                        // in_op / in_chain are don't-care on the B beat
                        alu_b   <= in_data;
                        r_state <= S_EXEC;
                    end else if (w_timeout) begin
                        err     <= 1'b1;
                        r_wdog  <= 8'h00;
                        r_state <= S_A;
                    end else if (r_wdog != 8'hFF) begin
                        // Saturate so a disabled watchdog cannot wrap
                        r_wdog <= w_wdog_next[7:0];
                    end
                end
                S_EXEC: begin
                    out_data    <= alu_r;
                    out_flags   <= alu_flags;
                    r_acc       <= alu_r;
                    r_acc_valid <= 1'b1;
                    out_valid   <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        r_state   <= S_A;
                    end
                end
                default: r_state <= S_A;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_ctrl
//  Description : Directed self-checking bench for alu_seq_ctrl with a
//                behavioural ALU core attached to the operand lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_op;
    logic       in_chain;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_r;
    logic [3:0] alu_flags;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_flags;
    logic [7:0] op_count;
    logic       err;
    logic       busy;

    int tests;
    int fails;

    alu_seq_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_chain  (in_chain),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_r     (alu_r),
        .alu_flags (alu_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .op_count  (op_count),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU core: 000 ADD, 001 SUB, 010 AND, 011 OR,
    // 100 SHL, 101 SHR, 110 NOT, 111 INC. C only for ADD/SUB, V only for ADD.
    always_comb begin
        logic [8:0] w_sum;
        logic       w_c;
        logic       w_v;
        w_sum = 9'h000;
        w_c   = 1'b0;
        w_v   = 1'b0;
        alu_r = 8'h00;
        case (alu_op)
            3'b000: begin
                w_sum = {1'b0, alu_a} + {1'b0, alu_b};
                alu_r = w_sum[7:0];
                w_c   = w_sum[8];
                w_v   = (alu_a[7] == alu_b[7]) && (alu_r[7] != alu_a[7]);
            end
            3'b001: begin
                alu_r = alu_a - alu_b;
                w_c   = (alu_a >= alu_b);
            end
            3'b010: alu_r = alu_a & alu_b;
            3'b011: alu_r = alu_a | alu_b;
            3'b100: alu_r = {alu_a[6:0], 1'b0};
            3'b101: alu_r = {1'b0, alu_a[7:1]};
            3'b110: alu_r = ~alu_a;
            default: alu_r = alu_a + 8'd1;
        endcase
        alu_flags = {(alu_r == 8'h00), alu_r[7], w_c, w_v};
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (op_count !== 8'h00) begin fails++; $display("FAIL reset_op_count: got %h want 00", op_count); end
        tests++; if ({alu_a, alu_b, alu_op} !== 19'h0) begin fails++; $display("FAIL reset_alu_regs: got %h want 0", {alu_a, alu_b, alu_op}); end
        tests++; if ({out_data, out_flags, err} !== 13'h0) begin fails++; $display("FAIL reset_out_regs: got %h want 0", {out_data, out_flags, err}); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h7F; in_op = 3'b000; in_chain = 1'b0;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL add_in_b_state: got ready=%b busy=%b want 1 1", in_ready, busy); end
        in_data = 8'h01; in_op = 3'b111;
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL add_exec_state: got valid=%b ready=%b want 0 0", out_valid, in_ready); end
        tests++; if (alu_a !== 8'h7F || alu_b !== 8'h01 || alu_op !== 3'b000) begin fails++; $display("FAIL add_operands: got a=%h b=%h op=%b want 7f 01 000", alu_a, alu_b, alu_op); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_latency: got out_valid=%b want 1", out_valid); end
        tests++; if (out_data !== 8'h80 || out_flags !== 4'b0101) begin fails++; $display("FAIL add_result: got %h/%b want 80/0101", out_data, out_flags); end
        @(negedge clk);
        tests++; if (op_count !== 8'd1 || out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL add_done: got cnt=%0d valid=%b busy=%b want 1 0 0", op_count, out_valid, busy); end
    endtask

    task automatic test_sub_chain();
        in_valid = 1'b1; in_data = 8'h05; in_op = 3'b001; in_chain = 1'b0;
        @(negedge clk);
        in_data = 8'h05;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        tests++; if (out_data !== 8'h00 || out_flags !== 4'b1010 || out_valid !== 1'b1) begin fails++; $display("FAIL sub_result: got %h/%b v=%b want 00/1010 1", out_data, out_flags, out_valid); end
        @(negedge clk);
        tests++; if (op_count !== 8'd2) begin fails++; $display("FAIL sub_count: got %0d want 2", op_count); end
        in_valid = 1'b1; in_data = 8'h80; in_op = 3'b000; in_chain = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_chain = 1'b0;
        tests++; if (in_ready !== 1'b0 || alu_a !== 8'h00 || alu_b !== 8'h80) begin fails++; $display("FAIL chain_operands: got rdy=%b a=%h b=%h want 0 00 80", in_ready, alu_a, alu_b); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b1 || out_data !== 8'h80 || out_flags !== 4'b0100) begin fails++; $display("FAIL chain_result: got v=%b %h/%b want 1 80/0100", out_valid, out_data, out_flags); end
        @(negedge clk);
        tests++; if (op_count !== 8'd3) begin fails++; $display("FAIL chain_count: got %0d want 3", op_count); end
    endtask

    task automatic test_unary_shl();
        in_valid = 1'b1; in_data = 8'h81; in_op = 3'b100; in_chain = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (alu_a !== 8'h81 || alu_b !== 8'h00 || out_valid !== 1'b0) begin fails++; $display("FAIL shl_operands: got a=%h b=%h v=%b want 81 00 0", alu_a, alu_b, out_valid); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b1 || out_data !== 8'h02 || out_flags !== 4'b0000) begin fails++; $display("FAIL shl_result: got v=%b %h/%b want 1 02/0000", out_valid, out_data, out_flags); end
        @(negedge clk);
        tests++; if (op_count !== 8'd4) begin fails++; $display("FAIL shl_count: got %0d want 4", op_count); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h10; in_op = 3'b000; in_chain = 1'b0;
        @(negedge clk);
        in_data = 8'h20;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== 8'h30 || out_flags !== 4'b0000 || in_ready !== 1'b0 || op_count !== 8'd4) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got v=%b %h/%b rdy=%b cnt=%0d want 1 30/0000 0 4", i, out_valid, out_data, out_flags, in_ready, op_count);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || op_count !== 8'd5) begin fails++; $display("FAIL bp_release: got v=%b cnt=%0d want 0 5", out_valid, op_count); end
        @(negedge clk);
        tests++; if (op_count !== 8'd5) begin fails++; $display("FAIL bp_single_inc: got %0d want 5", op_count); end
    endtask

    task automatic test_watchdog();
        in_valid = 1'b1; in_data = 8'h11; in_op = 3'b000; in_chain = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            tests++; if (err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL wd_wait[%0d]: got err=%b busy=%b want 0 1", i, err, busy); end
        end
        @(negedge clk);
        tests++; if (err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL wd_abort: got err=%b busy=%b want 1 0", err, busy); end
        tests++; if (op_count !== 8'd5 || out_data !== 8'h30 || out_valid !== 1'b0) begin fails++; $display("FAIL wd_unchanged: got cnt=%0d data=%h v=%b want 5 30 0", op_count, out_data, out_valid); end
        in_valid = 1'b1; in_data = 8'h01; in_op = 3'b000; in_chain = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_chain = 1'b0;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL wd_pulse_width: got err=%b want 0", err); end
        tests++; if (alu_a !== 8'h30 || alu_b !== 8'h01) begin fails++; $display("FAIL wd_new_a: got a=%h b=%h want 30 01", alu_a, alu_b); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b1 || out_data !== 8'h31) begin fails++; $display("FAIL wd_after_result: got v=%b %h want 1 31", out_valid, out_data); end
        @(negedge clk);
        tests++; if (op_count !== 8'd6) begin fails++; $display("FAIL wd_after_count: got %0d want 6", op_count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h40; in_op = 3'b100; in_chain = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (busy !== 1'b0 || out_valid !== 1'b0 || op_count !== 8'd0) begin fails++; $display("FAIL rst_exec_state: got busy=%b v=%b cnt=%0d want 0 0 0", busy, out_valid, op_count); end
        tests++; if ({alu_a, alu_b, alu_op, out_data, out_flags, err} !== 32'h0) begin fails++; $display("FAIL rst_exec_regs: got %h want 0", {alu_a, alu_b, alu_op, out_data, out_flags, err}); end
        in_valid = 1'b1; in_data = 8'h03; in_op = 3'b100;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        tests++; if (out_valid !== 1'b1 || out_data !== 8'h06) begin fails++; $display("FAIL rst_out_pre: got v=%b %h want 1 06", out_valid, out_data); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_flags !== 4'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rst_out_state: got v=%b %h/%b busy=%b rdy=%b want 0 00/0000 0 1", out_valid, out_data, out_flags, busy, in_ready); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h80; in_op = 3'b000; in_chain = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_chain = 1'b0;
        tests++; if (alu_a !== 8'h00 || alu_b !== 8'h80) begin fails++; $display("FAIL rst_chain_a: got a=%h b=%h want 00 80", alu_a, alu_b); end
        @(negedge clk);
        tests++; if (out_data !== 8'h80 || out_flags !== 4'b0100) begin fails++; $display("FAIL rst_chain_result: got %h/%b want 80/0100", out_data, out_flags); end
        @(negedge clk);
        tests++; if (op_count !== 8'd1) begin fails++; $display("FAIL rst_chain_count: got %0d want 1", op_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_op     = 3'b000;
        in_chain  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub_chain();
        test_unary_shl();
        test_backpressure();
        test_watchdog();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
